program_encoder: RTL and testbench
==================================

# program_encoder

Program encoder and loader for the 8-bit single-cycle CPU; it is the producer side of the opcode decode path. It accepts instruction fields (opcode, register indices, immediate) over a valid/ready handshake and packs them into 8-bit instruction words. The words are written sequentially into instruction memory while the CPU core is held in reset. The core is released once a HALT word has been written or the memory is full. Illegal opcodes are rejected and flagged.

## Interface
- ADDR_W, 4, instruction memory address width (depth 2^ADDR_W words)
- INSTR_W, 8, instruction word width (fixed at 8; other values unsupported)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load session (honoured in IDLE and DONE)
- enc_valid  in  1  instruction fields valid
- enc_ready  out  1  encoder accepts fields this cycle
- enc_opcode  in  4  opcode: HALT=0, LOAD=1, STORE=2, ADD=3, SUB=4, ADDI=5, JMP=6, AND=7
- enc_ra  in  2  destination/first register
- enc_rb  in  2  second source register
- enc_imm  in  4  immediate / jump target
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  8  packed instruction
- cpu_rst  out  1  holds the CPU core in reset
- load_done  out  1  program loaded, CPU running
- err_illegal  out  1  sticky: an opcode of 8–15 was offered
- err_full  out  1  sticky: memory filled without a HALT word
- word_count  out  ADDR_W+1  words written this session

## Operation
- Packing rules, all producing {opcode, low nibble}:
  - ADD, SUB, AND: {op, ra, rb}
  - LOAD, STORE, ADDI: {op, ra, imm[1:0]}; imm[3:2] are ignored
  - JMP: {op, imm}
  - HALT: {op, 4'b0000}
- States and outputs:
  - IDLE: cpu_rst=1, enc_ready=0. A start pulse moves to LOAD.
  - LOAD: enc_ready=1. On a handshake with an illegal opcode, the word is consumed, err_illegal is set, and nothing is written.
  - FLUSH: enc_ready=0. The final write is performed, then the block moves to DONE.
  - DONE: cpu_rst=0, load_done=1.
- Transition from LOAD to FLUSH happens on acceptance of a HALT word, or on acceptance of the word that fills address 2^ADDR_W−1.
- If the filling word is not HALT, err_full is set when the block enters FLUSH.
- A start pulse in DONE returns the block to LOAD:
  - cpu_rst=1, load_done=0
  - address and word_count reset to 0
  - error flags cleared
- A start pulse in LOAD or FLUSH is ignored.
- word_count increments by one per memory write and saturates at 2^ADDR_W.

## Timing
- All outputs are registered except enc_ready, which is decoded from the state.
- Reset values:
  - state IDLE, cpu_rst=1
  - enc_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - load_done=0, err_illegal=0, err_full=0, word_count=0
- Handshake in cycle N (enc_valid & enc_ready, legal opcode):
  - imem_we=1 in cycle N+1, with imem_addr equal to the address count at time N and the packed imem_wdata.
  - The address count advances in N+1.
  - Back-to-back handshakes give one write per cycle.
- Terminating word accepted in cycle N:
  - enc_ready=0 from N+1 (FLUSH)
  - write in N+1
  - DONE in N+2, with cpu_rst falling and load_done rising at N+2
- Address wrap: the address never wraps within a session; a full memory terminates the session.
- rst asserted in any state: the block returns to the reset values on the next edge. A pending write is dropped, and already-written memory is not cleared.
- start is accepted in the same cycle as entry into IDLE or DONE.

## Structure
- The shared CPU package holds the opcode localparams (shared with the decoder), the state encoding, and the field-slice constants (OPC_MSB=7, OPC_LSB=4).
- One sub-module: instr_packer. It is combinational: opcode and fields in; packed word and an illegal flag out.
- Top level: the FSM, address counter, and registered write port.

## Test plan
- Reset, then start, then ADD ra=1 rb=2 followed by HALT: imem writes 0x36 at addr 0 and 0x00 at addr 1. load_done=1 and cpu_rst=0 two cycles after the HALT handshake. word_count=2.
- ADDI ra=3 imm=0xE, JMP imm=9, then HALT:
  - writes 0x5E, 0x69, 0x00 on consecutive cycles
  - enc_valid is held high throughout, so there are no bubbles
- Opcode 0xA offered mid-stream: it is consumed with no write, err_illegal=1, the next legal word goes to the next address, and err_illegal stays set until the next start.
- 16 legal non-HALT words (ADDR_W=4):
  - writes to addr 0..15
  - enc_ready=0 after the 16th handshake
  - err_full=1, load_done=1, word_count=16
- rst pulse after 3 words in LOAD: all outputs return to reset values the next cycle and enc_ready=0. A new start begins again at addr 0.
- Stall with enc_valid toggled and a start pulse in DONE:
  - no write occurs without a handshake
  - the start pulse in DONE reasserts cpu_rst and restarts at addr 0

Source files
------------

// File: rtl/program_encoder_pkg.sv
// Shared CPU package: opcode values (also used by the decoder), the loader
// state encoding and the opcode field position inside an instruction word.
package program_encoder_pkg;

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/program_encoder_instr_packer.sv
// Combinational packer: builds {opcode, low nibble} from the instruction
// fields and flags opcodes outside the defined set.
module instr_packer
    import program_encoder_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] ra,
    input  logic [1:0] rb,
    input  logic [3:0] imm,
    output logic [7:0] word,
    output logic       illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[OPC_MSB:OPC_LSB] = opcode;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND:      word[OPC_LSB-1:0] = {ra, rb};
            // Only the two low immediate bits fit beside the register index.
            OP_LOAD, OP_STORE, OP_ADDI:  word[OPC_LSB-1:0] = {ra, imm[1:0]};
            OP_JMP:                      word[OPC_LSB-1:0] = imm;
            OP_HALT:                     word[OPC_LSB-1:0] = 4'b0000;
            default: begin
                word    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/program_encoder.sv
// Program loader: accepts instruction fields, writes packed words into
// instruction memory and holds the CPU in reset until the program is loaded.
module program_encoder
    import program_encoder_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               enc_valid,
    output logic               enc_ready,
    input  logic [3:0]         enc_opcode,
    input  logic [1:0]         enc_ra,
    input  logic [1:0]         enc_rb,
    input  logic [3:0]         enc_imm,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst,
    output logic               load_done,
    output logic               err_illegal,
    output logic               err_full,
    output logic [ADDR_W:0]    word_count
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t              state, next_state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [INSTR_W-1:0]  packed_word;
    logic                illegal;
    logic                hs, write_hs, at_last, is_halt, accept_term, restart;

    instr_packer u_packer (
        .opcode  (enc_opcode),
        .ra      (enc_ra),
        .rb      (enc_rb),
        .imm     (enc_imm),
        .word    (packed_word),
        .illegal (illegal)
    );

    // Handshake: fields transfer on a cycle where enc_valid and enc_ready are
    // both high; enc_ready depends only on state, never on enc_valid.
    assign enc_ready   = (state == S_LOAD);
    assign hs          = enc_valid & enc_ready;
    assign write_hs    = hs & ~illegal;
    assign at_last     = (addr_cnt == ADDR_LAST);
    assign is_halt     = (enc_opcode == OP_HALT);
    assign accept_term = write_hs & (is_halt | at_last);
    assign restart     = start & ((state == S_IDLE) | (state == S_DONE));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  if (accept_term) next_state = S_FLUSH;
            S_FLUSH: next_state = S_DONE;
            S_DONE:  if (start) next_state = S_LOAD;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_cnt    <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_rst     <= 1'b1;
            load_done   <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            word_count  <= '0;
        end else begin
            state     <= next_state;
            // Registered from next_state so both flip on the edge into DONE.
            cpu_rst   <= (next_state != S_DONE);
            load_done <= (next_state == S_DONE);
            imem_we   <= write_hs;
            if (restart) begin
                addr_cnt    <= '0;
                word_count  <= '0;
                err_illegal <= 1'b0;
                err_full    <= 1'b0;
            end
            if (write_hs) begin
                imem_addr  <= addr_cnt;
                imem_wdata <= packed_word;
                if (!at_last) addr_cnt <= addr_cnt + 1'b1;
                if (word_count != COUNT_MAX) word_count <= word_count + 1'b1;
                if (at_last && !is_halt) err_full <= 1'b1;
            end
            if (hs && illegal) err_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_program_encoder.sv
// Bench for program_encoder: table vectors, directed multi-cycle sequences
// and random sessions checked against an arithmetic reference model.
module tb_program_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       enc_valid = 1'b0;
    logic       enc_ready;
    logic [3:0] enc_opcode = '0;
    logic [1:0] enc_ra = '0;
    logic [1:0] enc_rb = '0;
    logic [3:0] enc_imm = '0;
    logic       imem_we;
    logic [3:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_rst;
    logic       load_done;
    logic       err_illegal;
    logic       err_full;
    logic [4:0] word_count;

    program_encoder #(.ADDR_W(4), .INSTR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_opcode(enc_opcode), .enc_ra(enc_ra), .enc_rb(enc_rb), .enc_imm(enc_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .load_done(load_done),
        .err_illegal(err_illegal), .err_full(err_full), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected writes as {addr, data}
    logic [11:0] exp_q[$];

    int m_addr, m_count;
    bit m_ill, m_full, m_done;

    typedef struct {
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [3:0] imm;
        int         exp_word;   // -1 when the opcode is illegal
    } vec_t;

    vec_t tbl[9];

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int ref_pack(int op, int ra, int rb, int imm);
        case (op)
            0:       return 0;
            3, 4, 7: return op * 16 + ra * 4 + rb;
            1, 2, 5: return op * 16 + ra * 4 + (imm % 4);
            6:       return op * 16 + imm;
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                check("write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_cpu_rst"}, cpu_rst, 1);
        check({tag, "_enc_ready"}, enc_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_err_illegal"}, err_illegal, 0);
        check({tag, "_err_full"}, err_full, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_addr = 0; m_count = 0; m_ill = 0; m_full = 0; m_done = 0;
        check("start_cpu_rst", cpu_rst, 1);
        check("start_load_done", load_done, 0);
        check("start_enc_ready", enc_ready, 1);
        check("start_word_count", word_count, 0);
        check("start_err_illegal", err_illegal, 0);
        check("start_err_full", err_full, 0);
    endtask

    // Returns one sample point after the handshake edge.
    task automatic send(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [3:0] imm);
        int n = 0;
        enc_valid = 1'b1;
        enc_opcode = op; enc_ra = ra; enc_rb = rb; enc_imm = imm;
        while (!enc_ready && n < 20) begin
            tick();
            n++;
        end
        if (!enc_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got enc_ready 0 expected 1");
        end
        tick();
    endtask

    task automatic offer(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [3:0] imm);
        int w;
        w = ref_pack(op, ra, rb, imm);
        send(op, ra, rb, imm);
        check("we_after_hs", imem_we, (w >= 0) ? 1 : 0);
        if (w < 0) begin
            m_ill = 1;
        end else begin
            exp_q.push_back({4'(m_addr), 8'(w)});
            m_count++;
            if (op == 0 || m_addr == 15) begin
                m_done = 1;
                m_full = (op != 0);
                check("ready_low_after_term", enc_ready, 0);
                check("err_full_on_flush", err_full, m_full);
            end
            m_addr++;
        end
        check("err_illegal", err_illegal, m_ill);
    endtask

    task automatic finish_session();
        int n = 0;
        enc_valid = 1'b0;
        while (!load_done && n < 6) begin
            tick();
            n++;
        end
        check("end_load_done", load_done, 1);
        check("end_cpu_rst", cpu_rst, 0);
        check("end_enc_ready", enc_ready, 0);
        check("end_err_illegal", err_illegal, m_ill);
        check("end_err_full", err_full, m_full);
        check("end_word_count", word_count, m_count);
        check("end_writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        int a;
        logic [3:0] op;

        tbl[0] = '{4'h5, 2'd3, 2'd0, 4'hE, 'h5E};
        tbl[1] = '{4'h6, 2'd0, 2'd0, 4'h9, 'h69};
        tbl[2] = '{4'hA, 2'd1, 2'd1, 4'h3, -1};
        tbl[3] = '{4'h2, 2'd2, 2'd1, 4'h7, 'h2B};
        tbl[4] = '{4'h4, 2'd0, 2'd3, 4'hF, 'h43};
        tbl[5] = '{4'h7, 2'd3, 2'd3, 4'h0, 'h7F};
        tbl[6] = '{4'h1, 2'd1, 2'd2, 4'hD, 'h15};
        tbl[7] = '{4'h3, 2'd2, 2'd1, 4'h0, 'h39};
        tbl[8] = '{4'h0, 2'd3, 2'd3, 4'hF, 'h00};

        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check_reset_vals("idle");

        // ADD r1,r2 then HALT with release timing
        do_start();
        offer(4'h3, 2'd1, 2'd2, 4'h0);
        check("t1_addr0", imem_addr, 0);
        check("t1_data0", imem_wdata, 'h36);
        offer(4'h0, 2'd0, 2'd0, 4'h0);
        check("t1_addr1", imem_addr, 1);
        check("t1_data1", imem_wdata, 'h00);
        check("t1_flush_cpu_rst", cpu_rst, 1);
        check("t1_flush_load_done", load_done, 0);
        tick();
        check("t1_done_load_done", load_done, 1);
        check("t1_done_cpu_rst", cpu_rst, 0);
        finish_session();

        // Table session, enc_valid held high throughout
        do_start();
        a = 0;
        for (int i = 0; i < 9; i++) begin
            offer(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].imm);
            if (tbl[i].exp_word >= 0) begin
                check("tbl_addr", imem_addr, a);
                check("tbl_word", imem_wdata, tbl[i].exp_word);
                a++;
            end
        end
        finish_session();

        // 16 non-HALT words fill memory
        do_start();
        for (int i = 0; i < 16; i++)
            offer(4'($urandom_range(1, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        check("full_addr15", imem_addr, 15);
        finish_session();
        check("full_err_full", err_full, 1);
        check("full_word_count", word_count, 16);

        // HALT landing on the last address is not a fill error
        do_start();
        for (int i = 0; i < 15; i++)
            offer(4'($urandom_range(1, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        offer(4'h0, 2'd1, 2'd1, 4'h1);
        finish_session();

        // rst after 3 words in LOAD, then a fresh session from addr 0
        do_start();
        for (int i = 0; i < 3; i++) offer(4'h3, 2'(i), 2'd1, 4'h0);
        enc_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        check("midrst_queue", exp_q.size(), 0);
        do_start();
        offer(4'h7, 2'd2, 2'd2, 4'h0);
        check("midrst_addr0", imem_addr, 0);
        offer(4'h0, 2'd0, 2'd0, 4'h0);
        finish_session();

        // Random sessions with stalls and ignored start pulses in LOAD
        for (int s = 0; s < 10; s++) begin
            do_start();
            while (!m_done) begin
                if ($urandom_range(0, 3) == 0) begin
                    enc_valid = 1'b0;
                    enc_opcode = 4'($urandom_range(0, 15));
                    start = ($urandom_range(0, 2) == 0);
                    tick();
                    start = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
                a = $urandom_range(0, 19);
                if (a < 2)      op = 4'h0;
                else if (a < 5) op = 4'($urandom_range(8, 15));
                else            op = 4'($urandom_range(1, 7));
                offer(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)));
            end
            finish_session();
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
